// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle for wide_add_sequencer.
// Carries the producer-side operand handshake (in_*), the consumer-side result handshake (out_*) and the busy flag.
// Producer and consumer attach through modport master; the sequencer attaches through modport slave. in_sub exists only with WIDE_ADD_SUB_EN.
interface wide_add_sequencer_if #(
    parameter int NWORDS = 4
);
    localparam int W = 32 * NWORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
`ifdef WIDE_ADD_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    modport master (
`ifdef WIDE_ADD_SUB_EN
        output in_sub,
`endif
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );

    modport slave (
`ifdef WIDE_ADD_SUB_EN
        input  in_sub,
`endif
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );
endinterface

// File: rtl/wide_add_sequencer.sv
// Purpose: adds two 32*NWORDS-bit operands on one shared 32-bit ripple-carry adder, one word per clock, LSW first.
// Latency: result valid after the NWORDS-th edge following the accept edge; one operation per NWORDS+2 cycles.
// Backpressure: in_ready only in IDLE; result and carry held stable in DONE until out_ready.
//
// Ports: clk, rst_n (async, active low); bus (wide_add_sequencer_if.slave):
//   in_valid/in_ready/in_a/in_b/in_cin[/in_sub] operand handshake,
//   out_valid/out_ready/out_sum/out_cout result handshake, busy (RUN or DONE).
// Optional feature macro: WIDE_ADD_SUB_EN adds in_sub (A - B via ~B and forced carry-in of 1).
module wide_add_sequencer #(
    parameter int NWORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    wide_add_sequencer_if.slave     bus
);
    localparam int W  = 32 * NWORDS;
    localparam int IW = $clog2(NWORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic [IW-1:0] idx_q, idx_d;

    // Shared 32-bit datapath: operands are words selected from captured
    // registers and carry-in is carry_q, so the ripple chain is the only
    // logic between flops.
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        add_cout;
    logic        rc_c;

    assign add_a = a_q[32*int'(idx_q) +: 32];
    assign add_b = b_q[32*int'(idx_q) +: 32];

    always_comb begin : ripple_carry_adder32
        add_sum = '0;
        rc_c    = carry_q;
        for (int i = 0; i < 32; i++) begin
            add_sum[i] = add_a[i] ^ add_b[i] ^ rc_c;
            rc_c       = (add_a[i] & add_b[i]) | (rc_c & (add_a[i] ^ add_b[i]));
        end
        add_cout = rc_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
`ifdef WIDE_ADD_SUB_EN
                    // Two's-complement subtract: A + ~B + 1.
                    if (bus.in_sub) begin
                        b_d     = ~bus.in_b;
                        carry_d = 1'b1;
                    end
`endif
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[32*int'(idx_q) +: 32] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-precision adder controller that time-shares one `RippleCarryAdder32` instance to add operands of `32*NWORDS` bits, one 32-bit word per clock, least-significant word first. Each word's carry-out is registered and fed back as the next word's carry-in. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It is the sequencing layer that lets the existing 32-bit ripple-carry datapath serve wide arithmetic without replicating adders.

## Interface
- `NWORDS`, default 4: number of 32-bit words per operand; legal range 2..16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand set presented.
- `in_ready` output 1: block can accept operands.
- `in_a` input `32*NWORDS`: operand A; word k is bits `[32k+31:32k]`.
- `in_b` input `32*NWORDS`: operand B.
- `in_cin` input 1: initial carry-in; ignored when `in_sub`=1.
- `in_sub` input 1: subtract request; exists only with `WIDE_ADD_SUB_EN`.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output `32*NWORDS`: result.
- `out_cout` output 1: final carry-out of word `NWORDS-1`.
- `busy` output 1: high in RUN or DONE.

## Operation
- There is one internal `RippleCarryAdder32`. Its `A`, `B` and `Cin` inputs are driven only from registers: the current word of the captured A, the current word of the captured B, and `carry_q`.
- The block is a state machine with three states: IDLE, RUN and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, capture `in_a` and `in_b`, set `carry_q`=`in_cin`, set `idx`=0, and go to RUN.
- RUN:
  - Each cycle, write the adder `Sum` into `out_sum` word `idx`, set `carry_q` ← `Cout`, and increment `idx`.
  - When `idx`==`NWORDS-1`, also latch `out_cout` ← `Cout` and go to DONE.
- DONE:
  - `out_valid`=1, and `out_sum`/`out_cout` are held stable.
  - On `out_ready`=1, go to IDLE.
- `in_ready` is asserted only in IDLE. A new operation never overlaps the previous one.
- `idx` is `$clog2(NWORDS)` bits wide. The terminal compare is `NWORDS-1`, so `idx` never wraps inside an operation.
- Arithmetic: `out_sum`/`out_cout` equal `{A + B + cin}` modulo `2^(32*NWORDS+1)`.
- Simultaneous events:
  - `out_ready` is high in the cycle DONE is entered: the handshake completes on the next edge.
  - `in_valid` is held high after a completed operation: it is accepted the cycle after IDLE is re-entered. There is no same-cycle DONE→accept.

## Timing
- Reset values, asynchronous on `rst_n`=0:
  - state=IDLE.
  - `in_ready`=1.
  - `out_valid`=0.
  - `out_sum`=0.
  - `out_cout`=0.
  - `busy`=0.
  - `carry_q`=0.
  - `idx`=0.
- Latency: the accept edge is cycle 0. RUN occupies cycles 1..`NWORDS`, and `out_valid` rises after edge `NWORDS`. With `NWORDS`=4, `out_valid` is high from cycle 5.
- Throughput: one operation per `NWORDS`+2 cycles when `out_ready` is held at 1.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. All outputs return to their reset values, and the partial result is discarded.
- Timing path: adder inputs are register outputs, and the adder output lands in a register. The 32-bit ripple is the single-cycle critical path.

## Configuration
- `WIDE_ADD_SUB_EN` defined:
  - The `in_sub` port exists.
  - An accept with `in_sub`=1 captures `~in_b` and forces `carry_q`=1, so the result is A−B.
  - `out_cout`=1 means no borrow (A ≥ B unsigned).
- `WIDE_ADD_SUB_EN` undefined:
  - There is no `in_sub` port and no inversion logic.
  - The block performs addition only.

## Test plan
All scenarios use `NWORDS`=4.
- All-ones plus one: A=2^128−1, B=1, cin=0 → `out_sum`=0, `out_cout`=1. `out_valid` is first high 5 cycles after accept.
- Cross-word carry: A=0x0000_0000_0000_0000_0000_0001_FFFF_FFFF, B=1 → `out_sum`=0x…0002_0000_0000, `out_cout`=0.
- Carry-in only: A=B=0, cin=1 → `out_sum`=1, `out_cout`=0.
- Backpressure: `out_ready`=0 for 3 cycles in DONE → `out_sum` is stable, `out_valid`=1, and `in_ready`=0 throughout. Raising `out_ready` returns the block to IDLE on the next cycle.
- Mid-operation reset: `rst_n` is pulsed low during RUN word 2 → `out_valid`=0 and `out_sum`=0 immediately. `in_ready`=1 after release, and the next operation (5+7) yields 12.
- With `WIDE_ADD_SUB_EN`: A=0, B=1, `in_sub`=1 → `out_sum`=2^128−1, `out_cout`=0. A=5, B=3 → `out_sum`=2, `out_cout`=1.
